// File: rtl/counter_mod_if.sv
// counter_mod_if
//   Control/status bundle for counter_mod.
//   master : drives enable, up_down, clear, load, load_value, ovf_clr
//            and observes count, at_max, at_min, tc, ovf.
//   slave  : the counter side of the same signals.
interface counter_mod_if #(
   parameter int WIDTH = 8
);
   logic             enable;
   logic             up_down;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             ovf_clr;
   logic [WIDTH-1:0] count;
   logic             at_max;
   logic             at_min;
   logic             tc;
   logic             ovf;

   modport master (
      output enable, up_down, clear, load, load_value, ovf_clr,
      input  count, at_max, at_min, tc, ovf
   );

   modport slave (
      input  enable, up_down, clear, load, load_value, ovf_clr,
      output count, at_max, at_min, tc, ovf
   );
endinterface

// File: rtl/counter_mod.sv
// counter_mod
//   Parametrised up/down modulo counter with prescaler, synchronous
//   clear/load, wrap or saturate at the range ends, a registered
//   terminal-count pulse and a sticky overflow flag.
// Ports
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-low reset
//   bus     : counter_mod_if.slave
//             in  enable, up_down, clear, load, load_value, ovf_clr
//             out count (reg), at_max/at_min (comb), tc (reg pulse), ovf (sticky)
module counter_mod #(
   parameter int WIDTH       = 8,
   parameter int MODULUS     = 256,
   parameter bit SATURATE    = 1'b0,
   parameter int PRESCALE    = 1,
   parameter int RESET_VALUE = 0
) (
   input  logic           i_clk,
   input  logic           i_reset,
   counter_mod_if.slave   bus
);
   localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RV    = WIDTH'(RESET_VALUE);
   // One extra bit so MODULUS == 2**WIDTH is representable.
   localparam logic [WIDTH:0] MOD_W   = (WIDTH+1)'(MODULUS);

   logic [WIDTH-1:0] r_count;
   logic [PW-1:0]    r_pre;
   logic             r_tc;
   logic             r_ovf;

   logic             w_at_max;
   logic             w_at_min;
   logic             w_step;
   logic             w_bnd;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_load;

   assign w_at_max = (r_count == MAXV);
   assign w_at_min = (r_count == '0);

   // A step only exists when neither clear nor load wins the cycle.
   assign w_step = bus.enable & (r_pre == PS_LAST) & ~bus.clear & ~bus.load;
   assign w_bnd  = w_step & (bus.up_down ? w_at_max : w_at_min);

   // Range ends are tested explicitly, so no arithmetic ever leaves
   // 0..MODULUS-1 and a full-width modulus wraps the same way.
   always_comb begin
      w_next = r_count;
      if (bus.up_down) begin
         if (w_at_max) w_next = SATURATE ? MAXV : '0;
         else          w_next = r_count + 1'b1;
      end else begin
         if (w_at_min) w_next = SATURATE ? '0 : MAXV;
         else          w_next = r_count - 1'b1;
      end
   end

   assign w_load = ({1'b0, bus.load_value} >= MOD_W) ? MAXV : bus.load_value;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_count <= RV;
         r_pre   <= '0;
         r_tc    <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_tc  <= w_bnd;
         // Setting beats both clear sources in the same cycle.
         r_ovf <= w_bnd | (r_ovf & ~bus.clear & ~bus.ovf_clr);
         if (bus.clear) begin
            r_count <= RV;
            r_pre   <= '0;
         end else if (bus.load) begin
            r_count <= w_load;
            r_pre   <= '0;
         end else if (bus.enable) begin
            // Prescaler holds when enable is low.
            r_pre <= w_step ? '0 : r_pre + 1'b1;
            if (w_step) r_count <= w_next;
         end
      end
   end

   assign bus.count  = r_count;
   assign bus.at_max = w_at_max;
   assign bus.at_min = w_at_min;
   assign bus.tc     = r_tc;
   assign bus.ovf    = r_ovf;
endmodule

// File: tb/tb_counter_mod.sv
module tb_counter_mod;
   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   counter_mod_if #(.WIDTH(8)) ifa ();   // defaults
   counter_mod_if #(.WIDTH(4)) ifb ();   // modulus 10, prescale 3
   counter_mod_if #(.WIDTH(4)) ifc ();   // modulus 10, saturate
   counter_mod_if #(.WIDTH(8)) ifd ();   // modulus 100, reset value 5

   counter_mod u_a (.i_clk(clk), .i_reset(rst_n), .bus(ifa));
   counter_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(3))
      u_b (.i_clk(clk), .i_reset(rst_n), .bus(ifb));
   counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1))
      u_c (.i_clk(clk), .i_reset(rst_n), .bus(ifc));
   counter_mod #(.WIDTH(8), .MODULUS(100), .RESET_VALUE(5))
      u_d (.i_clk(clk), .i_reset(rst_n), .bus(ifd));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en, up, clr, ld, oc;
      logic [7:0] lv;
      logic [7:0] cnt;
      logic       tc, ovf, mx, mn;
   } vec_t;

   vec_t vt[14];

   function automatic vec_t mk(bit en, bit up, bit clr, bit ld, bit oc, int lv,
                               int cnt, bit tc, bit ovf, bit mx, bit mn);
      vec_t r;
      r.en = en; r.up = up; r.clr = clr; r.ld = ld; r.oc = oc;
      r.lv = 8'(lv); r.cnt = 8'(cnt);
      r.tc = tc; r.ovf = ovf; r.mx = mx; r.mn = mn;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      ifa.enable = 0; ifa.up_down = 1; ifa.clear = 0; ifa.load = 0; ifa.load_value = 0; ifa.ovf_clr = 0;
      ifb.enable = 0; ifb.up_down = 1; ifb.clear = 0; ifb.load = 0; ifb.load_value = 0; ifb.ovf_clr = 0;
      ifc.enable = 0; ifc.up_down = 1; ifc.clear = 0; ifc.load = 0; ifc.load_value = 0; ifc.ovf_clr = 0;
      ifd.enable = 0; ifd.up_down = 1; ifd.clear = 0; ifd.load = 0; ifd.load_value = 0; ifd.ovf_clr = 0;
   endtask

   initial begin
      int exp_c;
      n_tests = 0;
      n_fail  = 0;
      idle_all();

      // load/clear/step vectors for the modulus-100, reset-value-5 instance
      vt[0]  = mk(0,0,0,1,0,200,  99,0,0,1,0);  // load clamps
      vt[1]  = mk(1,1,0,0,0,  0,   0,1,1,0,1);  // wrap up
      vt[2]  = mk(1,1,0,0,0,  0,   1,0,1,0,0);
      vt[3]  = mk(0,0,1,1,0, 50,   5,0,0,0,0);  // clear beats load, clears ovf
      vt[4]  = mk(1,1,0,1,0,  0,   0,0,0,0,1);  // load beats step
      vt[5]  = mk(1,0,0,0,0,  0,  99,1,1,1,0);  // wrap down
      vt[6]  = mk(1,0,0,0,1,  0,  98,0,0,0,0);  // ovf_clr
      vt[7]  = mk(0,0,0,1,0, 99,  99,0,0,1,0);
      vt[8]  = mk(0,0,0,1,0,100,  99,0,0,1,0);  // clamp at exactly the modulus
      vt[9]  = mk(1,1,0,0,1,  0,   0,1,1,0,1);  // set beats ovf_clr
      vt[10] = mk(0,1,0,0,0,  0,   0,0,1,0,1);  // tc drops, ovf sticky
      vt[11] = mk(1,1,1,0,0,  0,   5,0,0,0,0);  // clear beats step
      vt[12] = mk(0,0,0,1,0, 42,  42,0,0,0,0);
      vt[13] = mk(1,0,0,0,0,  0,  41,0,0,0,0);

      rst_n = 1'b0;
      #20;
      chk("rst_a_count", 32'(ifa.count), 32'd0);
      chk("rst_d_count", 32'(ifd.count), 32'd5);
      chk("rst_a_tc_ovf", 32'({ifa.tc, ifa.ovf}), 32'd0);
      rst_n = 1'b1;

      // Test 1: defaults, free-run up for 300 cycles
      ifa.enable = 1; ifa.up_down = 1;
      for (int i = 1; i <= 300; i++) begin
         tick();
         chk($sformatf("t1_count_%0d", i), 32'(ifa.count), 32'(i % 256));
         chk($sformatf("t1_tc_ovf_%0d", i), 32'({ifa.tc, ifa.ovf}),
             32'({(i == 256), (i >= 256)}));
      end
      ifa.enable = 0;

      // Table vectors
      for (int k = 0; k < 14; k++) begin
         ifd.enable = vt[k].en; ifd.up_down = vt[k].up; ifd.clear = vt[k].clr;
         ifd.load = vt[k].ld; ifd.ovf_clr = vt[k].oc; ifd.load_value = vt[k].lv;
         tick();
         chk($sformatf("vec%0d_count", k), 32'(ifd.count), 32'(vt[k].cnt));
         chk($sformatf("vec%0d_flags", k), 32'({ifd.tc, ifd.ovf, ifd.at_max, ifd.at_min}),
             32'({vt[k].tc, vt[k].ovf, vt[k].mx, vt[k].mn}));
      end
      ifd.enable = 0; ifd.load = 0; ifd.clear = 0; ifd.ovf_clr = 0;

      // Test 3: saturating down from 2
      ifc.load = 1; ifc.load_value = 4'd2;
      tick();
      chk("sat_load", 32'(ifc.count), 32'd2);
      ifc.load = 0; ifc.enable = 1; ifc.up_down = 0;
      tick(); chk("sat_d1", 32'({ifc.count, ifc.tc, ifc.ovf}), 32'({4'd1, 1'b0, 1'b0}));
      tick(); chk("sat_d0", 32'({ifc.count, ifc.tc, ifc.ovf}), 32'({4'd0, 1'b0, 1'b0}));
      tick(); chk("sat_h0a", 32'({ifc.count, ifc.tc, ifc.ovf}), 32'({4'd0, 1'b1, 1'b1}));
      tick(); chk("sat_h0b", 32'({ifc.count, ifc.tc, ifc.ovf}), 32'({4'd0, 1'b1, 1'b1}));
      ifc.ovf_clr = 1;
      tick(); chk("sat_set_vs_clr", 32'({ifc.count, ifc.tc, ifc.ovf}), 32'({4'd0, 1'b1, 1'b1}));
      ifc.enable = 0;
      tick(); chk("sat_ovf_clr", 32'({ifc.count, ifc.tc, ifc.ovf}), 32'({4'd0, 1'b0, 1'b0}));
      ifc.ovf_clr = 0; ifc.load = 1; ifc.load_value = 4'd9;
      tick();
      ifc.load = 0; ifc.enable = 1; ifc.up_down = 1;
      tick(); chk("sat_up_hold", 32'({ifc.count, ifc.tc, ifc.at_max}), 32'({4'd9, 1'b1, 1'b1}));
      ifc.enable = 0;

      // Test 2: prescale by 3, modulus 10
      ifb.enable = 1; ifb.up_down = 1;
      for (int n = 1; n <= 30; n++) begin
         tick();
         chk($sformatf("ps_count_%0d", n), 32'(ifb.count), 32'((n / 3) % 10));
         chk($sformatf("ps_tc_%0d", n), 32'(ifb.tc), 32'(n == 30));
      end
      tick();                        // prescaler 1
      ifb.enable = 0;
      for (int n = 0; n < 4; n++) tick();
      chk("ps_hold", 32'(ifb.count), 32'd0);
      ifb.enable = 1;
      tick(); chk("ps_pre2", 32'(ifb.count), 32'd0);
      ifb.up_down = 0;               // flip direction mid-prescale
      tick(); chk("ps_step_dn", 32'({ifb.count, ifb.tc}), 32'({4'd9, 1'b1}));
      ifb.enable = 0;

      // Test 6: direction flip at the boundary
      ifa.load = 1; ifa.load_value = 8'd255;
      tick();
      chk("flip_load", 32'({ifa.count, ifa.at_max, ifa.at_min}), 32'({8'd255, 1'b1, 1'b0}));
      ifa.load = 0; ifa.enable = 1; ifa.up_down = 1;
      tick();
      chk("flip_up", 32'({ifa.count, ifa.tc, ifa.at_max, ifa.at_min}), 32'({8'd0, 1'b1, 1'b0, 1'b1}));
      ifa.up_down = 0;
      tick();
      chk("flip_dn", 32'({ifa.count, ifa.tc, ifa.at_max, ifa.at_min}), 32'({8'd255, 1'b1, 1'b1, 1'b0}));
      ifa.enable = 0;
      tick();
      chk("flip_tc_drop", 32'(ifa.tc), 32'd0);

      // Test 5: async reset mid-count
      ifa.load = 1; ifa.load_value = 8'd56;
      tick();
      ifa.load = 0; ifa.enable = 1; ifa.up_down = 1;
      tick();
      chk("pre_rst_count", 32'({ifa.count, ifa.ovf}), 32'({8'd57, 1'b1}));
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_a", 32'({ifa.count, ifa.tc, ifa.ovf}), 32'd0);
      chk("async_rst_d", 32'(ifd.count), 32'd5);
      rst_n = 1'b1;
      exp_c = 1;
      tick();
      chk("resume", 32'(ifa.count), 32'(exp_c));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end
endmodule
